// File: rtl/box_frame_buffer_if.sv
// box_frame_buffer_if: box stream in, published frame bus and replay handshake out.
interface box_frame_buffer_if #(
   parameter int MAX_BOX_NUM = 16,
   parameter int BOX_WIDTH   = 38
);
   localparam int CNT_W = $clog2(MAX_BOX_NUM + 1);
   logic                           vs_in;
   logic                           eoc_in;
   logic [BOX_WIDTH-1:0]           box_in;
   logic                           frame_tick;
   logic [CNT_W-1:0]               box_count_out;
   logic [MAX_BOX_NUM-1:0]         box_valid_mask;
   logic                           overflow_out;
   logic [MAX_BOX_NUM*BOX_WIDTH-1:0] box_all_out;
   logic                           rd_valid;
   logic                           rd_ready;
   logic [BOX_WIDTH-1:0]           rd_data;
   logic [CNT_W-1:0]               rd_idx;
   logic                           rd_last;
   logic                           rd_abort;
   modport master (
      output vs_in, eoc_in, box_in, rd_ready,
      input  frame_tick, box_count_out, box_valid_mask, overflow_out, box_all_out,
             rd_valid, rd_data, rd_idx, rd_last, rd_abort
   );
   modport slave (
      input  vs_in, eoc_in, box_in, rd_ready,
      output frame_tick, box_count_out, box_valid_mask, overflow_out, box_all_out,
             rd_valid, rd_data, rd_idx, rd_last, rd_abort
   );
endinterface

// File: rtl/box_frame_buffer.sv
// box_frame_buffer: double-buffered per-frame box collector with stable published bus and replay port.
module box_frame_buffer #(
   parameter int MAX_BOX_NUM = 16,
   parameter int BOX_WIDTH   = 38
) (
   input logic              clk,
   input logic              rst_n,
   box_frame_buffer_if.slave bus
);
   localparam int CNT_W = $clog2(MAX_BOX_NUM + 1);
   localparam int IDX_W = (MAX_BOX_NUM > 1) ? $clog2(MAX_BOX_NUM) : 1;
   typedef enum logic {IDLE, STREAM} state_t;
   state_t                 state_q;
   logic                   vs_q, wr_sel_q, pub_sel_q, ovf_q, tick_q, ovf_out_q;
   logic                   rd_valid_q, rd_last_q, abort_q;
   logic [CNT_W-1:0]       wr_count_q, count_q, rd_idx_q, count_d, rd_idx_d;
   logic [MAX_BOX_NUM-1:0] mask_q, mask_d;
   logic [BOX_WIDTH-1:0]   rd_data_q, first_d, next_data_d;
   logic [BOX_WIDTH-1:0]   bank_q [2][MAX_BOX_NUM];
   logic                   bnd, acc, ovf_d, xfer;
   assign bnd  = bus.vs_in & ~vs_q;
   assign acc  = bus.eoc_in && (wr_count_q < CNT_W'(MAX_BOX_NUM));
   assign xfer = rd_valid_q & bus.rd_ready;
   always_comb begin
      count_d = wr_count_q + CNT_W'(acc);
      ovf_d   = ovf_q | (bus.eoc_in & ~acc);
      for (int i = 0; i < MAX_BOX_NUM; i++) mask_d[i] = i < int'(count_d);
      // slot 0 may be written in the boundary cycle itself, so bypass the bank
      first_d     = (acc && wr_count_q == '0) ? bus.box_in : bank_q[wr_sel_q][0];
      rd_idx_d    = rd_idx_q + CNT_W'(1);
      next_data_d = bank_q[pub_sel_q][rd_idx_d[IDX_W-1:0]];
   end
   always_ff @(posedge clk)
      if (acc) bank_q[wr_sel_q][wr_count_q[IDX_W-1:0]] <= bus.box_in;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         vs_q       <= 1'b0;
         wr_sel_q   <= 1'b0;
         pub_sel_q  <= 1'b1;
         ovf_q      <= 1'b0;
         wr_count_q <= '0;
         tick_q     <= 1'b0;
         count_q    <= '0;
         mask_q     <= '0;
         ovf_out_q  <= 1'b0;
         state_q    <= IDLE;
         rd_valid_q <= 1'b0;
         rd_idx_q   <= '0;
         rd_data_q  <= '0;
         rd_last_q  <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         vs_q    <= bus.vs_in;
         tick_q  <= bnd;
         abort_q <= bnd && state_q == STREAM;
         if (bnd) begin
            pub_sel_q  <= wr_sel_q;
            wr_sel_q   <= ~wr_sel_q;
            count_q    <= count_d;
            ovf_out_q  <= ovf_d;
            mask_q     <= mask_d;
            wr_count_q <= '0;
            ovf_q      <= 1'b0;
            state_q    <= (count_d != '0) ? STREAM : IDLE;
            rd_valid_q <= count_d != '0;
            rd_idx_q   <= '0;
            rd_data_q  <= (count_d != '0) ? first_d : '0;
            rd_last_q  <= count_d == CNT_W'(1);
         end else begin
            wr_count_q <= count_d;
            ovf_q      <= ovf_d;
            if (state_q == STREAM && xfer) begin
               if (rd_last_q) begin
                  state_q    <= IDLE;
                  rd_valid_q <= 1'b0;
                  rd_last_q  <= 1'b0;
               end else begin
                  rd_idx_q  <= rd_idx_d;
                  rd_data_q <= next_data_d;
                  rd_last_q <= rd_idx_d == count_q - CNT_W'(1);
               end
            end
         end
      end
   for (genvar g = 0; g < MAX_BOX_NUM; g++) begin : g_slot
      assign bus.box_all_out[g*BOX_WIDTH +: BOX_WIDTH] = bank_q[pub_sel_q][g] & {BOX_WIDTH{mask_q[g]}};
   end
   assign bus.frame_tick     = tick_q;
   assign bus.box_count_out  = count_q;
   assign bus.box_valid_mask = mask_q;
   assign bus.overflow_out   = ovf_out_q;
   assign bus.rd_valid       = rd_valid_q;
   assign bus.rd_data        = rd_data_q;
   assign bus.rd_idx         = rd_idx_q;
   assign bus.rd_last        = rd_last_q;
   assign bus.rd_abort       = abort_q;
endmodule

// File: tb/tb_box_frame_buffer.sv
// tb_box_frame_buffer: directed scenario tasks with hand-computed expectations for box_frame_buffer.
module tb_box_frame_buffer;
   localparam int N = 16;
   localparam int W = 38;
   localparam logic [W-1:0] A = 38'h0A_0000_000A, B = 38'h0B_0000_000B, C = 38'h0C_0000_000C;
   localparam logic [W-1:0] D = 38'h0D_0000_000D, Y = 38'h1E_0000_00EE;
   localparam logic [W-1:0] Q0 = 38'h11_0000_0001, Q1 = 38'h11_0000_0002;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [N*W-1:0] ea;
   box_frame_buffer_if #(.MAX_BOX_NUM(N), .BOX_WIDTH(W)) bus ();
   box_frame_buffer #(.MAX_BOX_NUM(N), .BOX_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] v);
      bus.eoc_in = 1'b1; bus.box_in = v; step(); bus.eoc_in = 1'b0;
   endtask

   task automatic test_reset();
      bus.vs_in = 0; bus.eoc_in = 0; bus.box_in = '0; bus.rd_ready = 0;
      step(); step(); step();
      checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL rst_tick: got %b expected 0", bus.frame_tick); end
      checks++; if (bus.box_count_out !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus.box_count_out); end
      checks++; if (bus.box_valid_mask !== 16'h0) begin errors++; $display("FAIL rst_mask: got %h expected 0", bus.box_valid_mask); end
      checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.overflow_out); end
      checks++; if (bus.box_all_out !== '0) begin errors++; $display("FAIL rst_all: got %h expected 0", bus.box_all_out); end
      checks++; if ({bus.rd_valid, bus.rd_last, bus.rd_abort, bus.rd_idx} !== 8'd0) begin errors++; $display("FAIL rst_rd: got v%b l%b a%b i%0d expected all 0", bus.rd_valid, bus.rd_last, bus.rd_abort, bus.rd_idx); end
      checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL rst_rd_data: got %h expected 0", bus.rd_data); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_empty_frame();
      bus.vs_in = 1; step();
      checks++; if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL empty_tick: got %b expected 1", bus.frame_tick); end
      checks++; if (bus.box_count_out !== 5'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", bus.box_count_out); end
      checks++; if (bus.box_valid_mask !== 16'h0) begin errors++; $display("FAIL empty_mask: got %h expected 0", bus.box_valid_mask); end
      checks++; if (bus.box_all_out !== '0) begin errors++; $display("FAIL empty_all: got %h expected 0", bus.box_all_out); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_valid: got %b expected 0", bus.rd_valid); end
      bus.vs_in = 0; step();
      checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL empty_tick_pulse: got %b expected 0", bus.frame_tick); end
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL empty_rd_valid2: got %b expected 0", bus.rd_valid); end
   endtask

   task automatic test_three_boxes();
      push(A); push(B); push(C);
      bus.vs_in = 1; step();
      ea = '0; ea[0 +: W] = A; ea[W +: W] = B; ea[2*W +: W] = C;
      checks++; if (bus.frame_tick !== 1'b1) begin errors++; $display("FAIL three_tick: got %b expected 1", bus.frame_tick); end
      checks++; if (bus.box_count_out !== 5'd3) begin errors++; $display("FAIL three_count: got %0d expected 3", bus.box_count_out); end
      checks++; if (bus.box_valid_mask !== 16'h0007) begin errors++; $display("FAIL three_mask: got %h expected 0007", bus.box_valid_mask); end
      checks++; if (bus.box_all_out !== ea) begin errors++; $display("FAIL three_all: got %h expected %h", bus.box_all_out, ea); end
      checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL three_ovf: got %b expected 0", bus.overflow_out); end
      checks++; if ({bus.rd_valid, bus.rd_idx, bus.rd_last} !== {1'b1, 5'd0, 1'b0}) begin errors++; $display("FAIL three_rd_start: got v%b i%0d l%b expected v1 i0 l0", bus.rd_valid, bus.rd_idx, bus.rd_last); end
      checks++; if (bus.rd_data !== A) begin errors++; $display("FAIL three_rd_data: got %h expected %h", bus.rd_data, A); end
      bus.vs_in = 0; push(D); step();
      checks++; if (bus.box_all_out !== ea || bus.box_count_out !== 5'd3) begin errors++; $display("FAIL three_stable: got count %0d all %h expected 3 %h", bus.box_count_out, bus.box_all_out, ea); end
      bus.vs_in = 1; step(); bus.vs_in = 0; step();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < N + 2; i++) push(38'h2A_0000_0000 | W'(i));
      bus.vs_in = 1; step();
      ea = '0;
      for (int i = 0; i < N; i++) ea[i*W +: W] = 38'h2A_0000_0000 | W'(i);
      checks++; if (bus.box_count_out !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", bus.box_count_out); end
      checks++; if (bus.box_valid_mask !== 16'hFFFF) begin errors++; $display("FAIL ovf_mask: got %h expected ffff", bus.box_valid_mask); end
      checks++; if (bus.overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow_out); end
      checks++; if (bus.box_all_out !== ea) begin errors++; $display("FAIL ovf_all: got %h expected %h", bus.box_all_out, ea); end
      checks++; if (bus.rd_abort !== 1'b1) begin errors++; $display("FAIL ovf_abort: got %b expected 1", bus.rd_abort); end
      bus.vs_in = 0; step();
      checks++; if (bus.rd_abort !== 1'b0) begin errors++; $display("FAIL ovf_abort_pulse: got %b expected 0", bus.rd_abort); end
      bus.vs_in = 1; step();
      checks++; if (bus.overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow_out); end
      checks++; if (bus.box_count_out !== 5'd0 || bus.box_valid_mask !== 16'h0) begin errors++; $display("FAIL ovf_empty: got count %0d mask %h expected 0 0", bus.box_count_out, bus.box_valid_mask); end
      checks++; if (bus.rd_valid !== 1'b0 || bus.rd_abort !== 1'b1) begin errors++; $display("FAIL ovf_empty_rd: got v%b a%b expected v0 a1", bus.rd_valid, bus.rd_abort); end
      bus.vs_in = 0; step();
   endtask

   task automatic test_coincident();
      bus.vs_in = 1; bus.eoc_in = 1; bus.box_in = D; step();
      checks++; if (bus.box_count_out !== 5'd1 || bus.box_all_out !== {{(N-1)*W{1'b0}}, D}) begin errors++; $display("FAIL coin_pub: got count %0d slot0 %h expected 1 %h", bus.box_count_out, bus.box_all_out[W-1:0], D); end
      checks++; if ({bus.rd_valid, bus.rd_last} !== 2'b11 || bus.rd_data !== D) begin errors++; $display("FAIL coin_rd: got v%b l%b d%h expected v1 l1 d%h", bus.rd_valid, bus.rd_last, bus.rd_data, D); end
      bus.box_in = Y; step();
      bus.eoc_in = 0; bus.vs_in = 0; step();
      bus.vs_in = 1; step();
      checks++; if (bus.box_count_out !== 5'd1 || bus.box_all_out !== {{(N-1)*W{1'b0}}, Y}) begin errors++; $display("FAIL coin_next: got count %0d slot0 %h expected 1 %h", bus.box_count_out, bus.box_all_out[W-1:0], Y); end
      checks++; if (bus.rd_data !== Y || bus.rd_abort !== 1'b1) begin errors++; $display("FAIL coin_next_rd: got d%h a%b expected d%h a1", bus.rd_data, bus.rd_abort, Y); end
      bus.vs_in = 0; bus.rd_ready = 1; step();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL coin_done: got v%b expected 0", bus.rd_valid); end
      bus.rd_ready = 0;
   endtask

   task automatic test_replay();
      push(A); push(B); push(C);
      bus.vs_in = 1; step();
      bus.vs_in = 0; bus.rd_ready = 1; step();
      checks++; if ({bus.rd_valid, bus.rd_idx, bus.rd_last} !== {1'b1, 5'd1, 1'b0} || bus.rd_data !== B) begin errors++; $display("FAIL rep_idx1: got v%b i%0d l%b d%h expected v1 i1 l0 d%h", bus.rd_valid, bus.rd_idx, bus.rd_last, bus.rd_data, B); end
      bus.rd_ready = 0; step();
      checks++; if ({bus.rd_valid, bus.rd_idx, bus.rd_last} !== {1'b1, 5'd1, 1'b0} || bus.rd_data !== B) begin errors++; $display("FAIL rep_hold1: got v%b i%0d l%b d%h expected v1 i1 l0 d%h", bus.rd_valid, bus.rd_idx, bus.rd_last, bus.rd_data, B); end
      bus.rd_ready = 1; step();
      checks++; if ({bus.rd_valid, bus.rd_idx, bus.rd_last} !== {1'b1, 5'd2, 1'b1} || bus.rd_data !== C) begin errors++; $display("FAIL rep_idx2: got v%b i%0d l%b d%h expected v1 i2 l1 d%h", bus.rd_valid, bus.rd_idx, bus.rd_last, bus.rd_data, C); end
      bus.rd_ready = 0; step();
      checks++; if ({bus.rd_valid, bus.rd_idx, bus.rd_last} !== {1'b1, 5'd2, 1'b1} || bus.rd_data !== C) begin errors++; $display("FAIL rep_hold2: got v%b i%0d l%b d%h expected v1 i2 l1 d%h", bus.rd_valid, bus.rd_idx, bus.rd_last, bus.rd_data, C); end
      bus.rd_ready = 1; step();
      checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rep_end: got v%b expected 0", bus.rd_valid); end
      bus.rd_ready = 0; step();
   endtask

   task automatic test_abort();
      push(A); push(B); push(C);
      bus.vs_in = 1; step();
      bus.vs_in = 0; bus.rd_ready = 1; bus.eoc_in = 1; bus.box_in = Q0; step();
      checks++; if (bus.rd_idx !== 5'd1) begin errors++; $display("FAIL abort_pre_idx: got %0d expected 1", bus.rd_idx); end
      bus.rd_ready = 0; bus.box_in = Q1; step();
      bus.eoc_in = 0; bus.vs_in = 1; step();
      checks++; if (bus.rd_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", bus.rd_abort); end
      checks++; if ({bus.rd_valid, bus.rd_idx, bus.rd_last} !== {1'b1, 5'd0, 1'b0} || bus.rd_data !== Q0) begin errors++; $display("FAIL abort_restart: got v%b i%0d l%b d%h expected v1 i0 l0 d%h", bus.rd_valid, bus.rd_idx, bus.rd_last, bus.rd_data, Q0); end
      checks++; if (bus.box_count_out !== 5'd2) begin errors++; $display("FAIL abort_count: got %0d expected 2", bus.box_count_out); end
      bus.vs_in = 0; step();
      checks++; if (bus.rd_abort !== 1'b0 || bus.rd_idx !== 5'd0) begin errors++; $display("FAIL abort_after: got a%b i%0d expected a0 i0", bus.rd_abort, bus.rd_idx); end
   endtask

   task automatic test_reset_mid();
      push(B);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({bus.rd_valid, bus.frame_tick, bus.box_count_out} !== 7'd0 || bus.box_all_out !== '0) begin errors++; $display("FAIL mid_rst: got v%b t%b c%0d expected all 0", bus.rd_valid, bus.frame_tick, bus.box_count_out); end
      step(); rst_n = 1'b1; step();
      push(C);
      bus.vs_in = 1; step();
      checks++; if (bus.box_count_out !== 5'd1 || bus.box_all_out !== {{(N-1)*W{1'b0}}, C}) begin errors++; $display("FAIL mid_pub: got count %0d slot0 %h expected 1 %h", bus.box_count_out, bus.box_all_out[W-1:0], C); end
      checks++; if ({bus.frame_tick, bus.rd_valid, bus.rd_abort} !== 3'b110 || bus.rd_data !== C) begin errors++; $display("FAIL mid_rd: got t%b v%b a%b d%h expected t1 v1 a0 d%h", bus.frame_tick, bus.rd_valid, bus.rd_abort, bus.rd_data, C); end
      bus.vs_in = 0; step();
   endtask

   initial begin
      test_reset();
      test_empty_frame();
      test_three_boxes();
      test_overflow();
      test_coincident();
      test_replay();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
